// File: rtl/estufa_pkg.sv
// Shared types and sensor-code constants for the multizone greenhouse controller.
package estufa_pkg;

  // Per-zone controller state, also exported on the LCD debug bus.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    HEAT  = 2'b01,
    COOL  = 2'b10,
    FAULT = 2'b11
  } zone_state_t;

  // Sensor code is {t1, t2}: t1 = temp >= 15 C, t2 = temp >= 20 C.
  localparam logic [1:0] COLD   = 2'b00;
  localparam logic [1:0] BAND   = 2'b10;
  localparam logic [1:0] HOT    = 2'b11;
  localparam logic [1:0] INCONS = 2'b01;

endpackage

// File: rtl/estufa_zona.sv
// One greenhouse zone: sensor debouncer, heater/cooler FSM with minimum run
// time, and a latched fault for inconsistent sensor readings.
// There are no handshakes here: every input is sampled on each clk_2 edge.
import estufa_pkg::*;

module estufa_zona #(
  parameter int DEB_CYCLES = 4,
  parameter int MIN_ON     = 8
) (
  input  logic        clk_2,
  input  logic        reset_n,
  input  logic        t1,
  input  logic        t2,
  input  logic        fault_clr,
  output logic        heat,
  output logic        cool,
  output logic        fault,
  output zone_state_t state
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int RW = $clog2(MIN_ON + 1);

  logic [1:0]    raw;
  logic [1:0]    raw_q;
  logic [1:0]    stable;
  logic [DW-1:0] deb_cnt;
  logic [DW-1:0] deb_next;
  logic [RW-1:0] run_cnt;
  logic          min_done;

  // Length of the current run of equal raw samples, including this edge's sample.
  // After reset the counter is 0, so the first sample always counts as 1.
  always_comb begin
    raw = {t1, t2};
    if (raw != raw_q)
      deb_next = DW'(1);
    else if (deb_cnt < DW'(DEB_CYCLES))
      deb_next = deb_cnt + DW'(1);
    else
      deb_next = deb_cnt;
  end

  // Debouncer: accept a raw code once it has been seen DEB_CYCLES edges in a row.
  always_ff @(posedge clk_2) begin
    if (!reset_n) begin
      raw_q   <= BAND;
      deb_cnt <= '0;
      stable  <= BAND;
    end else begin
      raw_q   <= raw;
      deb_cnt <= deb_next;
      if (deb_next == DW'(DEB_CYCLES))
        stable <= raw;
    end
  end

  // True once the zone has been in HEAT/COOL for at least MIN_ON edges.
  assign min_done = (run_cnt >= RW'(MIN_ON - 1));

  // Zone FSM plus run counter. An inconsistent code aborts HEAT/COOL at once;
  // otherwise HEAT/COOL always return through IDLE, never directly to each other.
  always_ff @(posedge clk_2) begin
    if (!reset_n) begin
      state   <= IDLE;
      run_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          run_cnt <= '0;
          if (stable == COLD)        state <= HEAT;
          else if (stable == HOT)    state <= COOL;
          else if (stable == INCONS) state <= FAULT;
        end
        HEAT: begin
          if (run_cnt < RW'(MIN_ON)) run_cnt <= run_cnt + RW'(1);
          if (stable == INCONS)                   state <= FAULT;
          else if (min_done && stable != COLD)    state <= IDLE;
        end
        COOL: begin
          if (run_cnt < RW'(MIN_ON)) run_cnt <= run_cnt + RW'(1);
          if (stable == INCONS)                   state <= FAULT;
          else if (min_done && stable != HOT)     state <= IDLE;
        end
        default: begin
          run_cnt <= '0;
          if (fault_clr && stable != INCONS) state <= IDLE;
        end
      endcase
    end
  end

  // Moore outputs decoded straight from the state register.
  assign heat  = (state == HEAT);
  assign cool  = (state == COOL);
  assign fault = (state == FAULT);

endmodule

// File: rtl/estufa_multizona.sv
// Multizone greenhouse controller: NZONES independent zone controllers sharing
// clock, reset and the global fault-clear request.
import estufa_pkg::*;

module estufa_multizona #(
  parameter int NZONES     = 4,
  parameter int DEB_CYCLES = 4,
  parameter int MIN_ON     = 8
) (
  input  logic                  clk_2,
  input  logic                  reset_n,
  input  logic [NZONES-1:0]     t1,
  input  logic [NZONES-1:0]     t2,
  input  logic                  fault_clr,
  output logic [NZONES-1:0]     heat,
  output logic [NZONES-1:0]     cool,
  output logic [NZONES-1:0]     fault,
  output logic                  any_fault,
  output logic [2*NZONES-1:0]   zone_state
);

  for (genvar g = 0; g < NZONES; g++) begin : g_zone
    zone_state_t st;

    estufa_zona #(
      .DEB_CYCLES(DEB_CYCLES),
      .MIN_ON    (MIN_ON)
    ) u_zona (
      .clk_2    (clk_2),
      .reset_n  (reset_n),
      .t1       (t1[g]),
      .t2       (t2[g]),
      .fault_clr(fault_clr),
      .heat     (heat[g]),
      .cool     (cool[g]),
      .fault    (fault[g]),
      .state    (st)
    );

    assign zone_state[2*g+1:2*g] = st;
  end

  assign any_fault = |fault;

endmodule
